prog_clock_divider: RTL

//  Multi-channel clock divider with a runtime-programmable integer divisor per channel. Each channel

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_channel.sv | 135 +++++++++++++
 rtl/prog_clock_divider.sv | 43 ++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  // Per-channel run state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } ch_state_t;

  // Smallest divisor that still produces a real output period
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: run FSM, period counter, pending-divisor register
// and the posedge/negedge flop pair that builds a 50% duty clk_out.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             div_err,
  output logic [DIV_W-1:0] div_cur,
  output logic             clk_out,
  output logic             tick
);

  ch_state_t        state;
  ch_state_t        state_next;
  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] count_next;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_q;
  logic             pend_v;
  logic             pos_q;
  logic             pos_next;
  logic             neg_q;
  logic             tick_q;
  logic             err_q;

  logic             wrap;
  logic [DIV_W:0]   half;
  logic             load_ok;
  logic             load_legal;

  // Last count of the current period and the length of the high phase.
  // half is one bit wider so (D+1) cannot overflow at the top of the range.
  assign wrap = (count == div_q - DIV_W'(1));
  assign half = ({1'b0, div_q} + (DIV_W + 1)'(1)) >> 1;

  // A load is taken only while nothing is pending; illegal values are flagged.
  assign load_ok    = div_valid & ~pend_v;
  assign load_legal = (div_in >= DIV_W'(MIN_DIV));

  // Next-state, next-count and next high-phase flag for the posedge flops
  always_comb begin
    state_next = state;
    count_next = count;
    pos_next   = pos_q;
    case (state)
      IDLE: begin
        count_next = '0;
        pos_next   = 1'b0;
        if (en) begin
          state_next = RUN;
          pos_next   = 1'b1;
        end
      end
      RUN: begin
        count_next = wrap ? '0 : count + DIV_W'(1);
        if (!en) state_next = wrap ? IDLE : STOP;
      end
      STOP: begin
        count_next = wrap ? '0 : count + DIV_W'(1);
        if (en)        state_next = RUN;
        else if (wrap) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        pos_next   = 1'b0;
      end
    endcase
    // Outside IDLE the high phase covers counts 0 .. H-1; dropping to IDLE
    // only happens at the wrap edge where pos_q is already low.
    if (state != IDLE) begin
      if (state_next == IDLE) begin
        count_next = '0;
        pos_next   = 1'b0;
      end else begin
        pos_next = ({1'b0, count_next} < half);
      end
    end
  end

  // Posedge state: FSM, counter, divisor handshake and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      pos_q  <= 1'b0;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
      div_q  <= DIV_W'(DEFAULT_DIV);
      pend_q <= '0;
      pend_v <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      pos_q  <= pos_next;
      tick_q <= (state_next != IDLE) && (count_next == '0);
      err_q  <= load_ok & ~load_legal;
      if (load_ok && load_legal) begin
        if (state == IDLE) begin
          // Nothing is running, so the new divisor can take effect at once
          // (including when this same edge starts the channel).
          div_q <= div_in;
        end else begin
          pend_q <= div_in;
          pend_v <= 1'b1;
        end
      end else if (pend_v && wrap && (state != IDLE)) begin
        // Swap divisors only at a period boundary so no period is cut short.
        div_q  <= pend_q;
        pend_v <= 1'b0;
      end
    end
  end

  // Half-cycle delayed copy of pos_q, used to stretch odd divisors to 50% duty
  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= (state == IDLE) ? 1'b0 : pos_q;
  end

  assign clk_out   = div_q[0] ? (pos_q & neg_q) : pos_q;
  assign tick      = tick_q;
  assign div_err   = err_q;
  assign div_ready = ~pend_v;
  assign div_cur   = div_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: one independent channel per
// bit of en, each slicing its own divisor field out of the packed buses.
module prog_clock_divider
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_valid,
  output logic [NUM_CH-1:0]       div_ready,
  output logic [NUM_CH-1:0]       div_err,
  output logic [NUM_CH*DIV_W-1:0] div_cur,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      clk_div_channel #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .en        (en[gi]),
        .div_in    (div_in[gi*DIV_W +: DIV_W]),
        .div_valid (div_valid[gi]),
        .div_ready (div_ready[gi]),
        .div_err   (div_err[gi]),
        .div_cur   (div_cur[gi*DIV_W +: DIV_W]),
        .clk_out   (clk_out[gi]),
        .tick      (tick[gi])
      );
    end
  endgenerate

endmodule
